// File: rtl/afe_spi_sequencer.sv
// afe_spi_sequencer: after start, walks the command ROM from address 0 and
// plays each "send" entry to the AFE as one mode-0 SPI frame (20 bits,
// MSB first). Ends in DONE on a stop opcode or after address 8'hFF, and in
// ERROR on a reserved opcode.
module afe_spi_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  rom_address,
  input  logic [23:0] rom_command,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  cmd_count
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_CS_SETUP = 4'd3;
  localparam logic [3:0] S_SHIFT    = 4'd4;
  localparam logic [3:0] S_CS_HOLD  = 4'd5;
  localparam logic [3:0] S_GAP      = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
  localparam logic [3:0] S_ERROR    = 4'd8;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  localparam logic [4:0] BIT_LAST = 5'd19;

  localparam logic [3:0] OP_STOP = 4'h0;
  localparam logic [3:0] OP_SEND = 4'h1;

  logic [3:0]  state;
  logic [7:0]  cnt;
  logic [4:0]  bit_cnt;
  logic [19:0] shreg;
  logic [3:0]  opcode;

  assign opcode = rom_command[23:20];

  // Frame counter never rolls over.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A bit period ends on the last cycle of the SCLK high phase.
  logic bit_end;
  assign bit_end = (state == S_SHIFT) && (cnt == DIV_LAST) && spi_sclk;

  // Sequencer FSM, phase counters and registered SPI/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      bit_cnt     <= 5'd0;
      rom_address <= 8'd0;
      spi_cs_n    <= 1'b1;
      spi_sclk    <= 1'b0;
      spi_mosi    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cmd_count   <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            rom_address <= 8'd0;
            cmd_count   <= 8'd0;
            done        <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_SEND: begin
              spi_cs_n <= 1'b0;
              spi_sclk <= 1'b0;
              spi_mosi <= rom_command[19];
              cnt      <= 8'd0;
              state    <= S_CS_SETUP;
            end
            OP_STOP: begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end
            default: begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_ERROR;
            end
          endcase
        end
        S_CS_SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt     <= 8'd0;
            bit_cnt <= 5'd0;
            state   <= S_SHIFT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= 8'd0;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
            end else begin
              spi_sclk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state <= S_CS_HOLD;
              end else begin
                bit_cnt  <= bit_cnt + 5'd1;
                spi_mosi <= shreg[18];
              end
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_CS_HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt       <= 8'd0;
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
            cmd_count <= sat_inc(cmd_count);
            state     <= S_GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= 8'd0;
            if (rom_address == 8'hFF) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              rom_address <= rom_address + 8'd1;
              state       <= S_FETCH;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Payload shift register: loaded at decode, shifted on each SCLK fall.
  always_ff @(posedge clk) begin
    if (state == S_DECODE && opcode == OP_SEND) begin
      shreg <= rom_command[19:0];
    end else if (bit_end && bit_cnt != BIT_LAST) begin
      shreg <= {shreg[18:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_afe_spi_sequencer.sv
// Directed bench for afe_spi_sequencer: registered ROM model, a negedge
// SPI monitor that records each frame, and hand-computed expectations.
module tb_afe_spi_sequencer;
  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rom_address;
  logic [23:0] rom_command;
  logic        spi_cs_n, spi_sclk, spi_mosi;
  logic        busy, done, error;
  logic [7:0]  cmd_count;

  afe_spi_sequencer #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_address(rom_address), .rom_command(rom_command),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .busy(busy), .done(done), .error(error), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  // Registered-address ROM model.
  logic [23:0] rom [256];
  always @(posedge clk) rom_command <= rom[rom_address];

  logic [19:0] init_tab [6] = '{20'h20A0E, 20'h0DB01, 20'h0F208,
                                20'h30B80, 20'h30C04, 20'h33A82};

  // SPI monitor: frame payloads, CS low/high lengths, SCLK rises per frame.
  logic [19:0] cap_q  [$];
  int          low_q  [$];
  int          hi_q   [$];
  int          edge_q [$];
  logic [19:0] cur_shift = '0;
  int          low_run = 0, high_run = 0, cur_edges = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (!spi_cs_n) begin
      if (prev_cs) begin
        hi_q.push_back(high_run);
        cur_edges = 0;
        low_run   = 0;
      end
      low_run++;
      if (spi_sclk && !prev_sclk) begin
        cur_edges++;
        cur_shift = {cur_shift[18:0], spi_mosi};
      end
    end else begin
      if (!prev_cs) begin
        cap_q.push_back(cur_shift);
        low_q.push_back(low_run);
        edge_q.push_back(cur_edges);
        high_run = 0;
      end
      high_run++;
    end
    prev_cs   = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic load_init();
    for (int i = 0; i < 256; i++) rom[i] = 24'h000000;
    for (int i = 0; i < 6; i++) rom[i] = {4'h1, init_tab[i]};
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int c = 0;
    while (!(done || error) && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check_val({tag, "_seq_end"}, 32'(done | error), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_init_frames(input string tag, input int base, input bit timing);
    check_val({tag, "_nframes"}, 32'(cap_q.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("%s_payload%0d", tag, i), 32'(cap_q[base+i]), 32'(init_tab[i]));
      if (timing) begin
        check_val($sformatf("%s_cslow%0d", tag, i), 32'(low_q[base+i]), 32'd168);
        check_val($sformatf("%s_sclkrise%0d", tag, i), 32'(edge_q[base+i]), 32'd20);
        if (i > 0) check_val($sformatf("%s_cshigh%0d", tag, i), 32'(hi_q[base+i]), 32'd10);
      end
    end
  endtask

  initial begin
    int base;
    int c;
    int rises;
    logic ps;

    reset = 1'b1;
    start = 1'b0;
    load_init();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check_val("rst_sclk", 32'(spi_sclk), 32'd0);
    check_val("rst_mosi", 32'(spi_mosi), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_error", 32'(error), 32'd0);
    check_val("rst_count", 32'(cmd_count), 32'd0);
    check_val("rst_addr", 32'(rom_address), 32'd0);
    reset = 1'b0;

    // Six-entry init table then stop, with frame timing.
    base = cap_q.size();
    pulse_start();
    check_val("t1_busy_on", 32'(busy), 32'd1);
    wait_end("t1", 2000);
    check_init_frames("t1", base, 1'b1);
    check_val("t1_count", 32'(cmd_count), 32'd6);
    check_val("t1_done", 32'(done), 32'd1);
    check_val("t1_busy", 32'(busy), 32'd0);
    check_val("t1_error", 32'(error), 32'd0);
    check_val("t1_addr", 32'(rom_address), 32'd6);

    // Reserved opcode at entry 2.
    rom[2] = 24'h312345;
    base = cap_q.size();
    pulse_start();
    wait_end("t3", 2000);
    check_val("t3_nframes", 32'(cap_q.size() - base), 32'd2);
    check_val("t3_payload0", 32'(cap_q[base]), 32'(init_tab[0]));
    check_val("t3_payload1", 32'(cap_q[base+1]), 32'(init_tab[1]));
    check_val("t3_error", 32'(error), 32'd1);
    check_val("t3_done", 32'(done), 32'd0);
    check_val("t3_busy", 32'(busy), 32'd0);
    check_val("t3_count", 32'(cmd_count), 32'd2);
    check_val("t3_addr", 32'(rom_address), 32'd2);

    // Second start during frame 1 is ignored.
    load_init();
    base = cap_q.size();
    pulse_start();
    c = 0;
    while (spi_cs_n && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    check_val("t4_cs_fall", 32'(spi_cs_n), 32'd0);
    repeat (50) @(posedge clk);
    pulse_start();
    wait_end("t4", 2000);
    check_init_frames("t4", base, 1'b0);
    check_val("t4_count", 32'(cmd_count), 32'd6);
    check_val("t4_addr", 32'(rom_address), 32'd6);

    // Reset at the 10th SCLK rise of frame 3, then replay.
    base = cap_q.size();
    pulse_start();
    c = 0;
    rises = 0;
    ps = 1'b0;
    while (rises < 10 && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
      if (cap_q.size() >= base + 2 && !spi_cs_n && spi_sclk && !ps) rises++;
      ps = spi_sclk;
    end
    check_val("t5_rises", 32'(rises), 32'd10);
    reset = 1'b1;
    #1;
    check_val("t5_cs_n", 32'(spi_cs_n), 32'd1);
    check_val("t5_sclk", 32'(spi_sclk), 32'd0);
    check_val("t5_mosi", 32'(spi_mosi), 32'd0);
    check_val("t5_busy", 32'(busy), 32'd0);
    check_val("t5_done", 32'(done), 32'd0);
    check_val("t5_error", 32'(error), 32'd0);
    check_val("t5_count", 32'(cmd_count), 32'd0);
    check_val("t5_addr", 32'(rom_address), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    base = cap_q.size();
    pulse_start();
    wait_end("t5r", 2000);
    check_init_frames("t5r", base, 1'b0);
    check_val("t5r_count", 32'(cmd_count), 32'd6);

    // Send opcode at every address: 256 frames, saturation, no wrap.
    for (int i = 0; i < 256; i++) rom[i] = {4'h1, 12'hA50, 8'(i)};
    base = cap_q.size();
    pulse_start();
    wait_end("t6", 47000);
    check_val("t6_nframes", 32'(cap_q.size() - base), 32'd256);
    check_val("t6_payload0", 32'(cap_q[base]), 32'h000A5000);
    check_val("t6_payload200", 32'(cap_q[base+200]), 32'h000A50C8);
    check_val("t6_payload255", 32'(cap_q[base+255]), 32'h000A50FF);
    check_val("t6_count", 32'(cmd_count), 32'hFF);
    check_val("t6_done", 32'(done), 32'd1);
    check_val("t6_addr", 32'(rom_address), 32'hFF);
    check_val("t6_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
